// File: rtl/uart_pkg.sv
// Shared UART definitions: configuration codes, bit-period divisor and TX FSM encoding.
// Imported by both the transmit and receive paths, so identical codes interoperate.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = DATA_BITS + 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clocks per bit, rounded to nearest so the line rate error stays below half a clock.
  function automatic int unsigned div_of(input int unsigned clk_freq,
                                         input logic [1:0]  baud_code);
    int unsigned baud;
    case (baud_code)
      BAUD_2400: baud = 2400;
      BAUD_4800: baud = 4800;
      BAUD_9600: baud = 9600;
      default:   baud = 19200;
    endcase
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data,
                                     input logic [1:0]           parity_code);
    case (parity_code)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: loadable down-counter producing a one-clock tick every DIV clocks.
// Held cleared while the transmitter idles; a load restarts the period immediately.
module uart_tx_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div - DIV_W'(1);
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= r_div - DIV_W'(1);
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_tick = (r_cnt == '0) && !i_clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frame (start, 8 data LSB-first, parity slot, stop).
// Byte, parity and divisor are latched on accept; the serial line is a registered output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       ready,
  output logic       active_flag,
  output logic       done_flag
);

  tx_state_e        r_state,   w_state_next;
  logic [7:0]       r_shreg,   w_shreg_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic             r_parity,  w_parity_next;
  logic             r_data_tx, w_data_tx_next;
  logic             r_ready;
  logic             r_active;
  logic             r_done,    w_done_next;
  logic             w_accept;
  logic             w_tick;
  logic             w_clear;
  logic [DIV_W-1:0] w_div;

  assign w_div   = DIV_W'(div_of(CLK_FREQ, baud_rate));
  assign w_clear = (r_state == ST_IDLE);

  uart_tx_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_clear (w_clear),
    .i_div   (w_div),
    .o_tick  (w_tick)
  );

  // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_idx_next = r_bit_idx;
    w_parity_next  = r_parity;
    w_done_next    = 1'b0;
    w_accept       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (send) begin
          w_accept       = 1'b1;
          w_shreg_next   = data_in;
          w_parity_next  = parity_of(data_in, parity_type);
          w_bit_idx_next = '0;
          w_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_PARITY;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shreg_next   = {1'b0, r_shreg[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Line level follows the next state so it changes on the same edge as the FSM.
    case (w_state_next)
      ST_START:  w_data_tx_next = 1'b0;
      ST_DATA:   w_data_tx_next = w_shreg_next[0];
      ST_PARITY: w_data_tx_next = w_parity_next;
      default:   w_data_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_parity  <= 1'b1;
      r_data_tx <= 1'b1;
      r_ready   <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_idx <= w_bit_idx_next;
      r_parity  <= w_parity_next;
      r_data_tx <= w_data_tx_next;
      r_ready   <= (w_state_next == ST_IDLE);
      r_active  <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
    end
  end

  assign data_tx     = r_data_tx;
  assign ready       = r_ready;
  assign active_flag = r_active;
  assign done_flag   = r_done;

endmodule
